// File: rtl/sm_tdm_poll_sched.sv
// Round-robin TDM endpoint poller: reads each enabled endpoint's size word,
// drains its payload and forwards every word downstream tagged with its endpoint.
module sm_tdm_poll_sched #(
    parameter int NUM_TDM_ENDPOINTS = 4,
    parameter int MAX_LEN = 8,
    parameter int POLL_GAP = 4,
    localparam int ENDP_WIDTH = $clog2(NUM_TDM_ENDPOINTS),
    localparam int MAX_WIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [NUM_TDM_ENDPOINTS-1:0] ep_mask,
    output logic                  rd_req,
    output logic [ENDP_WIDTH-1:0] rd_ep,
    input  logic                  rd_ack,
    input  logic [31:0]           rd_data,
    output logic                  mon_enable,
    output logic [31:0]           mon_data,
    output logic [ENDP_WIDTH-1:0] mon_ep,
    output logic                  pkt_done,
    output logic                  size_err,
    output logic                  busy
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SIZE,
        DRAIN,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [ENDP_WIDTH-1:0] ptr_q, ptr_d;
    logic [ENDP_WIDTH-1:0] ep_q, ep_d;
    logic [MAX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  hold_q, hold_d;

    logic                  ack;
    logic [MAX_WIDTH-1:0]  size_w;
    logic [ENDP_WIDTH-1:0] sel_ep;
    logic                  sel_hit;
    logic [ENDP_WIDTH-1:0] nxt_ptr;
    logic                  done_visit;

    assign rd_ep   = ep_q;
    assign busy    = (state_q != IDLE);
    assign rd_req  = ((state_q == SIZE) || (state_q == DRAIN)) && !hold_q;
    assign ack     = rd_req && rd_ack;
    assign size_w  = rd_data[MAX_WIDTH-1:0];
    assign nxt_ptr = (ep_q == ENDP_WIDTH'(NUM_TDM_ENDPOINTS - 1)) ?
                     '0 : ep_q + ENDP_WIDTH'(1);

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        int j;
        j       = 0;
        sel_ep  = '0;
        sel_hit = 1'b0;
        for (int i = NUM_TDM_ENDPOINTS - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_TDM_ENDPOINTS) begin
                j = j - NUM_TDM_ENDPOINTS;
            end
            if (ep_mask[ENDP_WIDTH'(j)]) begin
                sel_ep  = ENDP_WIDTH'(j);
                sel_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ep_d       = ep_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        hold_d     = 1'b0;
        done_visit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run && (|ep_mask)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (sel_hit) begin
                    ep_d    = sel_ep;
                    state_d = SIZE;
                end else begin
                    state_d = IDLE;
                end
            end
            SIZE: begin
                if (ack) begin
                    cnt_d = size_w;
                    if (size_w == '0) begin
                        done_visit = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        hold_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ack) begin
                    cnt_d = cnt_q - MAX_WIDTH'(1);
                    if (cnt_q == MAX_WIDTH'(1)) begin
                        done_visit = 1'b1;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    state_d = run ? SELECT : IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A zero gap skips the GAP state and decides run immediately.
        if (done_visit) begin
            ptr_d = nxt_ptr;
            gap_d = '0;
            if (POLL_GAP == 0) begin
                state_d = run ? SELECT : IDLE;
            end else begin
                state_d = GAP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ep_q       <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            hold_q     <= 1'b0;
            mon_enable <= 1'b0;
            mon_data   <= '0;
            mon_ep     <= '0;
            pkt_done   <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ep_q       <= ep_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            mon_enable <= ack;
            pkt_done   <= ack && (state_q == DRAIN) &&
                          (cnt_q == MAX_WIDTH'(1));
            size_err   <= ack && (state_q == SIZE) &&
                          (size_w > MAX_WIDTH'(MAX_LEN));
            if (ack) begin
                mon_data <= rd_data;
                mon_ep   <= ep_q;
            end
        end
    end

endmodule

// File: tb/tb_sm_tdm_poll_sched.sv
// Directed + randomized bench for sm_tdm_poll_sched with a visit-level
// reference model (round-robin pointer, per-visit word list).
module tb_sm_tdm_poll_sched;

    localparam int N = 4;
    localparam int MAX_LEN = 8;
    localparam int POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  ep_mask;
    logic        rd_req;
    logic [1:0]  rd_ep;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        mon_enable;
    logic [31:0] mon_data;
    logic [1:0]  mon_ep;
    logic        pkt_done;
    logic        size_err;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int ptr_m = 0;

    sm_tdm_poll_sched #(
        .NUM_TDM_ENDPOINTS(N),
        .MAX_LEN(MAX_LEN),
        .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .ep_mask(ep_mask),
        .rd_req(rd_req),
        .rd_ep(rd_ep),
        .rd_ack(rd_ack),
        .rd_data(rd_data),
        .mon_enable(mon_enable),
        .mon_data(mon_data),
        .mon_ep(mon_ep),
        .pkt_done(pkt_done),
        .size_err(size_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_ep(input logic [3:0] m, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (((m >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    // Idles until rd_req, throwing stray acks that must be ignored.
    task automatic wait_req(output int lows);
        lows = 0;
        while (rd_req !== 1'b1 && lows < 100) begin
            rd_ack  = 1'($urandom_range(0, 1));
            rd_data = $urandom;
            @(negedge clk);
            lows++;
            chk("quiet", {29'd0, mon_enable, pkt_done, size_err}, 0);
        end
        rd_ack = 1'b0;
        if (rd_req !== 1'b1) chk("req_timeout", {31'd0, rd_req}, 1);
    endtask

    task automatic do_read(input int ep, input logic [31:0] data,
                           input int dly, input logic pd, input logic se);
        logic [1:0] e;
        e = 2'(ep);
        chk("rd_ep", {30'd0, rd_ep}, {30'd0, e});
        for (int i = 0; i < dly; i++) begin
            rd_ack = 1'b0;
            @(negedge clk);
            chk("hold_req", {29'd0, rd_req, rd_ep}, {29'd0, 1'b1, e});
            chk("quiet_dly", {29'd0, mon_enable, pkt_done, size_err}, 0);
        end
        rd_ack  = 1'b1;
        rd_data = data;
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = $urandom;
        chk("mon_enable", {31'd0, mon_enable}, 1);
        chk("mon_data", mon_data, data);
        chk("mon_ep", {30'd0, mon_ep}, {30'd0, e});
        chk("pkt_done", {31'd0, pkt_done}, {31'd0, pd});
        chk("size_err", {31'd0, size_err}, {31'd0, se});
        chk("req_drop", {31'd0, rd_req}, 0);
    endtask

    // One endpoint visit: size word then size payload words.
    task automatic visit(input logic [3:0] m, input logic [31:0] size_word,
                         input int dmin, input int dmax, input int exp_gap);
        int ep;
        int lows;
        int sz;
        wait_req(lows);
        if (exp_gap >= 0) chk("gap_cycles", lows, exp_gap);
        ep = next_ep(m, ptr_m);
        sz = int'(size_word[3:0]);
        do_read(ep, size_word, $urandom_range(dmin, dmax), 1'b0,
                sz > MAX_LEN);
        for (int k = 1; k <= sz; k++) begin
            wait_req(lows);
            chk("word_gap", lows, 1);
            do_read(ep, $urandom, $urandom_range(dmin, dmax), k == sz, 1'b0);
        end
        ptr_m = (ep + 1) % N;
    endtask

    initial begin
        int ep;
        int lows;
        logic [3:0] m;
        rst = 1'b1;
        run = 1'b0;
        ep_mask = 4'h0;
        rd_ack = 1'b0;
        rd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {26'd0, rd_req, rd_ep, mon_enable, pkt_done,
            size_err, busy}, 0);
        chk("rst_mon", {30'd0, mon_ep} | mon_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        // all endpoints, size 0
        run = 1'b1;
        ep_mask = 4'hF;
        visit(4'hF, 32'd0, 0, 0, -1);
        repeat (4) visit(4'hF, 32'd0, 0, 1, POLL_GAP + 1);

        // sparse mask, 3-word packet on ep2, then ep0
        ep_mask = 4'b0101;
        visit(4'b0101, 32'd3, 0, 2, POLL_GAP + 1);
        visit(4'b0101, 32'd0, 0, 2, POLL_GAP + 1);

        // slow acks
        visit(4'b0101, 32'd2, 5, 5, POLL_GAP + 1);

        // oversize length still drained
        visit(4'b0101, 32'h0000_000F, 0, 1, POLL_GAP + 1);

        // randomized masks, sizes and ack latency
        repeat (25) begin
            m = 4'($urandom_range(1, 15));
            ep_mask = m;
            visit(m, $urandom, 0, 3, POLL_GAP + 1);
        end

        // run and mask dropped mid-packet
        ep_mask = 4'hF;
        wait_req(lows);
        chk("gap_cycles", lows, POLL_GAP + 1);
        ep = next_ep(4'hF, ptr_m);
        do_read(ep, 32'd3, 0, 1'b0, 1'b0);
        wait_req(lows);
        do_read(ep, 32'hA0A0_0001, 1, 1'b0, 1'b0);
        run = 1'b0;
        ep_mask = 4'h0;
        wait_req(lows);
        chk("word_gap", lows, 1);
        do_read(ep, 32'hB0B0_0002, 0, 1'b0, 1'b0);
        wait_req(lows);
        do_read(ep, 32'hC0C0_0003, 2, 1'b1, 1'b0);
        ptr_m = (ep + 1) % N;
        for (int i = 1; i < POLL_GAP; i++) begin
            chk("gap_busy", {30'd0, busy, rd_req}, 2);
            @(negedge clk);
        end
        chk("gap_busy", {30'd0, busy, rd_req}, 2);
        repeat (3) begin
            @(negedge clk);
            chk("idle_after", {30'd0, busy, rd_req}, 0);
        end

        // async reset between size ack and payload ack
        run = 1'b1;
        ep_mask = 4'hF;
        wait_req(lows);
        ep = next_ep(4'hF, ptr_m);
        do_read(ep, 32'd3, 0, 1'b0, 1'b0);
        wait_req(lows);
        #2 rst = 1'b1;
        rd_ack = 1'b1;
        #1;
        chk("async_rst", {26'd0, rd_req, rd_ep, mon_enable, pkt_done,
            size_err, busy}, 0);
        chk("async_rst_mon", {30'd0, mon_ep} | mon_data, 0);
        @(negedge clk);
        rd_ack = 1'b0;
        rst = 1'b0;
        ptr_m = 0;
        visit(4'hF, 32'd0, 0, 1, -1);
        visit(4'hF, 32'd2, 0, 1, POLL_GAP + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
